// File: rtl/vector_lane_sequencer.sv
// Per-iteration index sequencer for the lane datapath: drives the split-side
// issue index and, through a PIPE-deep delay line, the join-side write-back index.
module vector_lane_sequencer #(
    parameter  int unsigned V     = 20,
    parameter  int unsigned LANES = 4,
    parameter  int unsigned PIPE  = 1,
    parameter  int unsigned OPW   = 4,
    localparam int unsigned ITER  = V / LANES,
    localparam int unsigned IW    = (ITER > 1) ? $clog2(ITER) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start_i,
    input  logic [OPW-1:0] op_i,
    input  logic           stall_i,
    input  logic           abort_i,
    output logic [OPW-1:0] op_o,
    output logic           issue_valid_o,
    output logic [IW-1:0]  issue_idx_o,
    output logic           wb_valid_o,
    output logic [IW-1:0]  wb_idx_o,
    output logic           busy_o,
    output logic           done_o
);

    // Reject configurations the lane split cannot represent.
    if (((V % LANES) != 0) || (PIPE < 1) || (PIPE > 4)) begin : g_cfg_check
        $error("vector_lane_sequencer: V must be a multiple of LANES and PIPE in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            issue_idx_q, issue_idx_d;
    logic [OPW-1:0]           op_q, op_d;
    logic [PIPE-1:0]          vld_q, vld_d;
    logic [PIPE-1:0][IW-1:0]  idx_q, idx_d;
    logic                     push_v;

    // State, issue counter, opcode and delay-line registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            issue_idx_q <= '0;
            op_q        <= '0;
            vld_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            op_q        <= op_d;
            vld_q       <= vld_d;
            idx_q       <= idx_d;
        end
    end

    // Next-state, issue stepping and delay-line shift; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        op_d        = op_q;
        vld_d       = vld_q;
        idx_d       = idx_q;
        push_v      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = ISSUE;
                    op_d        = op_i;
                    issue_idx_d = '0;
                end
            end
            ISSUE: begin
                if (!stall_i) begin
                    push_v = 1'b1;
                    if (issue_idx_q == IW'(ITER - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        issue_idx_d = issue_idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!stall_i && vld_q[PIPE-1] && (idx_q[PIPE-1] == IW'(ITER - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bubbles enter the line whenever nothing is issued.
        if (!stall_i) begin
            for (int i = PIPE - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
                idx_d[i] = idx_q[i-1];
            end
            vld_d[0] = push_v;
            idx_d[0] = push_v ? issue_idx_q : '0;
        end

        if (abort_i && (state_q != IDLE)) begin
            state_d     = IDLE;
            issue_idx_d = '0;
            vld_d       = '0;
            idx_d       = '0;
        end
    end

    // Outputs decoded from registered state only (plus the stall qualifier).
    assign op_o          = op_q;
    assign issue_idx_o   = issue_idx_q;
    assign issue_valid_o = (state_q == ISSUE) && !stall_i;
    assign wb_idx_o      = idx_q[PIPE-1];
    assign wb_valid_o    = vld_q[PIPE-1] && !stall_i;
    assign busy_o        = (state_q == ISSUE) || (state_q == DRAIN);
    assign done_o        = (state_q == DONE);

endmodule
